// File: rtl/ppt_pkg.sv
// rtl/ppt_pkg.sv - shared definitions for the ppt pulse-train block
//
// Purpose : default field width, FSM state encoding and the I2C register
//           map that the register file and ppt_pulse_gen must agree on.
// Ports   : none (package).
// Config  : optional trigger output is enabled in ppt_pulse_gen by
//           defining PPT_TRIG_OUT_EN.

package ppt_pkg;

  localparam int PPT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ppt_state_e;

  localparam int REG_ADDR_W = 4;

  // Register map; 16-bit quantities are split into L/H byte registers.
  localparam logic [REG_ADDR_W-1:0] REG_PERIOD_L     = 4'h1;
  localparam logic [REG_ADDR_W-1:0] REG_PERIOD_H     = 4'h2;
  localparam logic [REG_ADDR_W-1:0] REG_WIDTH_L      = 4'h3;
  localparam logic [REG_ADDR_W-1:0] REG_WIDTH_H      = 4'h4;
  localparam logic [REG_ADDR_W-1:0] REG_COUNT_L      = 4'h5;
  localparam logic [REG_ADDR_W-1:0] REG_COUNT_H      = 4'h6;
  localparam logic [REG_ADDR_W-1:0] REG_RUN          = 4'h7;
  localparam logic [REG_ADDR_W-1:0] REG_COUNT_DONE_L = 4'h8;
  localparam logic [REG_ADDR_W-1:0] REG_COUNT_DONE_H = 4'h9;
  localparam logic [REG_ADDR_W-1:0] REG_DONE         = 4'hA;

  // Status registers are read-only from the host side.
  function automatic logic reg_is_status(input logic [REG_ADDR_W-1:0] addr);
    return (addr == REG_COUNT_DONE_L) || (addr == REG_COUNT_DONE_H) ||
           (addr == REG_DONE);
  endfunction

endpackage

// File: rtl/ppt_period_cnt.sv
// rtl/ppt_period_cnt.sv - wrapping cycle counter with terminal-count flag
//
// Purpose : counts 0..period-1 and wraps to 0 while enabled.
// Ports   : clk     - system clock
//           rst     - synchronous active-high reset (counter -> 0)
//           clear   - force counter to 0 on this edge (has priority over en)
//           en      - advance the counter
//           period  - wrap length in cycles (held stable by the caller)
//           cyc_nxt - value the counter takes on the next edge
//           tc      - current count is the last cycle of the period

module ppt_period_cnt
  import ppt_pkg::*;
#(
  parameter int CNT_W = PPT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cyc_nxt,
  output logic             tc
);

  logic [CNT_W-1:0] cyc;

  assign tc = (cyc == period - CNT_W'(1));

  // The next value is exported so the owner can register outputs that
  // line up with the counter value of the following cycle.
  always_comb begin
    cyc_nxt = cyc;
    if (clear) begin
      cyc_nxt = '0;
    end else if (en) begin
      cyc_nxt = tc ? '0 : cyc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
    end else begin
      cyc <= cyc_nxt;
    end
  end

endmodule

// File: rtl/ppt_pulse_gen.sv
// rtl/ppt_pulse_gen.sv - programmable pulse-train generator
//
// Purpose : emits count_i pulses of width_i high cycles every period_i
//           cycles while run_i is high (count_i = 0 runs forever), and
//           reports completed periods and a sticky done flag.
// Ports   : clk          - system clock (32.768 kHz)
//           rst          - synchronous active-high reset
//           run_i        - level enable; falling aborts the train
//           period_i     - cycles per period (0 = finish immediately)
//           width_i      - high cycles per period
//           count_i      - pulses to emit, 0 = continuous
//           pulse_o      - registered pulse train
//           busy_o       - high while the train is running
//           count_done_o - completed full periods since last start
//           trig_o       - one-cycle strobe on the first cycle of each
//                          period (only when PPT_TRIG_OUT_EN is defined)
//           done_o       - sticky finish flag, cleared when run_i drops

module ppt_pulse_gen
  import ppt_pkg::*;
#(
  parameter int CNT_W = PPT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] count_done_o,
`ifdef PPT_TRIG_OUT_EN
  output logic             trig_o,
`endif
  output logic             done_o
);

  ppt_state_e       state;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] width_sh;
  logic [CNT_W-1:0] count_sh;

  logic [CNT_W-1:0] cyc_nxt;
  logic             tc;
  logic             start;
  logic             cnt_en;
  logic [CNT_W-1:0] cd_inc;
  logic             last;

  assign start  = (state == IDLE) && run_i && (period_i != '0);
  assign cnt_en = (state == RUN) && run_i;
  assign cd_inc = count_done_o + CNT_W'(1);
  // Final period of a finite train completes on this edge.
  assign last   = tc && (count_sh != '0) && (cd_inc == count_sh);

  ppt_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .en      (cnt_en),
    .period  (period_sh),
    .cyc_nxt (cyc_nxt),
    .tc      (tc)
  );

  // pulse_o is registered from the counter's next value so that it equals
  // (cyc < width) in the same cycle, i.e. the first high cycle is the one
  // right after the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      period_sh    <= '0;
      width_sh     <= '0;
      count_sh     <= '0;
      pulse_o      <= 1'b0;
      busy_o       <= 1'b0;
      count_done_o <= '0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pulse_o <= 1'b0;
          busy_o  <= 1'b0;
          if (run_i) begin
            count_done_o <= '0;
            if (period_i != '0) begin
              state     <= RUN;
              period_sh <= period_i;
              width_sh  <= width_i;
              count_sh  <= count_i;
              busy_o    <= 1'b1;
              pulse_o   <= (width_i != '0);
            end else begin
              // Zero period: nothing to emit, report finished at once.
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!run_i) begin
            state   <= IDLE;
            pulse_o <= 1'b0;
            busy_o  <= 1'b0;
          end else if (last) begin
            state        <= DONE;
            count_done_o <= cd_inc;
            pulse_o      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
          end else begin
            if (tc) begin
              count_done_o <= cd_inc;
            end
            pulse_o <= (cyc_nxt < width_sh);
          end
        end

        DONE: begin
          pulse_o <= 1'b0;
          busy_o  <= 1'b0;
          // No auto-restart: run_i must drop before a new train.
          if (!run_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          pulse_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PPT_TRIG_OUT_EN
  logic trig_nxt;

  // Next cycle is cyc==0 of a period that will actually run.
  assign trig_nxt = start || (cnt_en && tc && !last);

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_o <= 1'b0;
    end else begin
      trig_o <= trig_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ppt_pulse_gen.sv
// tb/tb_ppt_pulse_gen.sv - self-checking bench for ppt_pulse_gen

module tb_ppt_pulse_gen;

`ifdef PPT_TRIG_OUT_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  localparam int TIMEOUT_CYC = 20000;

  typedef struct packed {
    logic        pulse;
    logic        busy;
    logic        done;
    logic [15:0] cd;
    logic        trig;
  } obs_t;

  typedef struct {
    obs_t exp;
    int   vec;
    int   k;
  } sb_t;

  typedef struct {
    logic [15:0] period;
    logic [15:0] width;
    logic [15:0] count;
    int          run_len;
    int          chg_at;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        run_i;
  logic [15:0] period_i;
  logic [15:0] width_i;
  logic [15:0] count_i;
  logic        pulse_o;
  logic        busy_o;
  logic [15:0] count_done_o;
  logic        done_o;
  logic        trig_w;

  sb_t sb[$];
  int  n_cmp;
  int  n_fail;
  bit  finished;

  ppt_pulse_gen #(
    .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run_i),
    .period_i     (period_i),
    .width_i      (width_i),
    .count_i      (count_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .count_done_o (count_done_o),
`ifdef PPT_TRIG_OUT_EN
    .trig_o       (trig_w),
`endif
    .done_o       (done_o)
  );

`ifndef PPT_TRIG_OUT_EN
  assign trig_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k cycles after the start edge (k = 0 is the cycle
  // right after it), assuming run_i is still high.
  function automatic obs_t exp_at(input int p, input int w, input int c, input int k);
    obs_t o;
    o = '0;
    if (p == 0) begin
      o.done = 1'b1;
    end else if (c != 0 && k >= c * p) begin
      o.done = 1'b1;
      o.cd   = 16'(c);
    end else begin
      o.busy  = 1'b1;
      o.pulse = ((k % p) < w);
      o.cd    = 16'(k / p);
      o.trig  = TRIG_EN && ((k % p) == 0);
    end
    return o;
  endfunction

  task automatic push(input obs_t e, input int vec, input int k);
    sb_t s;
    s.exp = e;
    s.vec = vec;
    s.k   = k;
    sb.push_back(s);
  endtask

  // Entered just after a posedge; configures, starts, runs run_len cycles,
  // drops run_i and records the idle cycle that follows.
  task automatic run_vec(input vec_t v, input int idx);
    obs_t e;
    obs_t last_e;
    period_i = v.period;
    width_i  = v.width;
    count_i  = v.count;
    run_i    = 1'b1;
    last_e   = '0;
    for (int k = 0; k < v.run_len; k++) begin
      @(posedge clk); #1;
      e = exp_at(int'(v.period), int'(v.width), int'(v.count), k);
      push(e, idx, k);
      last_e = e;
      if (k == v.chg_at) begin
        period_i = period_i + 16'd5;
        width_i  = width_i + 16'd3;
        count_i  = count_i + 16'd1;
      end
      if (k == v.run_len - 1) run_i = 1'b0;
    end
    @(posedge clk); #1;
    e    = '0;
    e.cd = last_e.cd;
    push(e, idx, v.run_len);
  endtask

  always @(negedge clk) begin
    sb_t  s;
    obs_t act;
    if (sb.size() > 0) begin
      s   = sb.pop_front();
      act = {pulse_o, busy_o, done_o, count_done_o, trig_w};
      n_cmp++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL vec%0d cyc%0d: got pulse=%0b busy=%0b done=%0b cd=%0d trig=%0b, expected pulse=%0b busy=%0b done=%0b cd=%0d trig=%0b",
                 s.vec, s.k, act.pulse, act.busy, act.done, act.cd, act.trig,
                 s.exp.pulse, s.exp.busy, s.exp.done, s.exp.cd, s.exp.trig);
      end
    end
  end

  initial begin
    finished = 1'b0;
    repeat (TIMEOUT_CYC) @(posedge clk);
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: bench did not finish within %0d cycles", TIMEOUT_CYC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  vec_t vecs[10];

  initial begin
    obs_t e;
    n_cmp  = 0;
    n_fail = 0;

    //            period  width  count  run_len chg_at
    vecs[0] = '{16'd32, 16'd4,  16'd50, 1610, -1};  // basic run to done
    vecs[1] = '{16'd32, 16'd4,  16'd50, 100,  -1};  // abort after 100
    vecs[2] = '{16'd32, 16'd4,  16'd50, 70,   -1};  // restart clears cd
    vecs[3] = '{16'd8,  16'd0,  16'd3,  30,   -1};  // width 0
    vecs[4] = '{16'd8,  16'd10, 16'd3,  30,   -1};  // width > period
    vecs[5] = '{16'd2,  16'd1,  16'd0,  1001, -1};  // continuous square
    vecs[6] = '{16'd0,  16'd5,  16'd3,  5,    -1};  // zero period
    vecs[7] = '{16'd16, 16'd5,  16'd4,  70,   10};  // config change in RUN
    vecs[8] = '{16'd1,  16'd1,  16'd5,  8,    -1};  // period 1
    vecs[9] = '{16'd5,  16'd4,  16'd2,  12,   -1};  // width = period-1

    rst      = 1'b1;
    run_i    = 1'b0;
    period_i = '0;
    width_i  = '0;
    count_i  = '0;
    @(posedge clk); #1; push('0, -1, 0);
    @(posedge clk); #1; push('0, -1, 1);
    n_cmp++;
    if ({pulse_o, busy_o, done_o, count_done_o, trig_w} !== '0) begin
      n_fail++;
      $display("FAIL reset state: pulse=%0b busy=%0b done=%0b cd=%0d trig=%0b",
               pulse_o, busy_o, done_o, count_done_o, trig_w);
    end
    rst = 1'b0;
    @(posedge clk); #1; push('0, -1, 2);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a high phase.
    period_i = 16'd32;
    width_i  = 16'd8;
    count_i  = 16'd0;
    run_i    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      push(exp_at(32, 8, 0, k), 10, k);
      if (k == 4) rst = 1'b1;
    end
    @(posedge clk); #1;
    e = '0;
    push(e, 10, 5);
    rst   = 1'b0;
    run_i = 1'b0;
    @(posedge clk); #1;
    push(e, 10, 6);

    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard not drained: %0d entries left", sb.size());
    end
    finished = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
